// File: rtl/program_loader.sv
// Program memory loader.
// Writes a byte stream into program memory from address 0, appends a terminator word,
// waits a fixed start delay, then enables the processor and hands it the memory port
// for read-only fetches.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   load_start          one-cycle pulse that (re)starts a load at address 0
//   in_valid/in_data/in_last/in_ready   byte stream handshake
//   mem_we/mem_addr/mem_wdata           single-port program memory
//   cpu_addr, cpu_gnt   processor fetch address and port grant
//   enable              processor run enable
//   busy                load, terminator write or start delay in progress
//   overflow            sticky: program did not fit before the terminator slot
//   byte_count          data bytes stored by the last load
module program_loader #(
  parameter int unsigned       ADDR_W      = 10,
  parameter int unsigned       DATA_W      = 8,
  parameter logic [DATA_W-1:0] TERM        = 8'hFF,
  parameter int unsigned       START_DELAY = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_gnt,
  output logic              enable,
  output logic              busy,
  output logic              overflow,
  output logic [ADDR_W:0]   byte_count
);

  typedef enum logic [2:0] {StIdle, StLoad, StTerm, StWait, StRun, StErr} state_e;

  // The top address is reserved for the terminator, so the last data slot is one below it.
  localparam logic [ADDR_W-1:0] LastAddr = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] FullAddr = LastAddr - 1'b1;
  localparam logic [3:0]        DelayMax = 4'(START_DELAY - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]     count_q, count_d;
  logic [3:0]          delay_q, delay_d;
  logic                ovf_q, ovf_d;
  logic [ADDR_W-1:0]   addr_hold_q;
  logic                accept;

  always_comb begin
    state_d   = state_q;
    wr_addr_d = wr_addr_q;
    count_d   = count_q;
    delay_d   = delay_q;
    ovf_d     = ovf_q;
    accept    = 1'b0;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_hold_q;
    mem_wdata = '0;
    cpu_gnt   = 1'b0;
    enable    = 1'b0;
    busy      = 1'b0;

    unique case (state_q)
      StIdle: ;
      StLoad: begin
        busy     = 1'b1;
        mem_addr = wr_addr_q;
        in_ready = (wr_addr_q < LastAddr) && !reset;
        accept   = in_valid && in_ready;
        if (accept) begin
          mem_we    = 1'b1;
          mem_wdata = in_data;
          wr_addr_d = wr_addr_q + 1'b1;
          count_d   = count_q + 1'b1;
          if (in_last) begin
            state_d = StTerm;
          end else if (wr_addr_q == FullAddr) begin
            // Data filled every slot below the terminator without an end marker.
            ovf_d   = 1'b1;
            state_d = StTerm;
          end
        end
      end
      StTerm: begin
        busy      = 1'b1;
        mem_we    = !reset;
        mem_addr  = wr_addr_q;
        mem_wdata = TERM;
        delay_d   = '0;
        state_d   = ovf_q ? StErr : StWait;
      end
      StWait: begin
        busy = 1'b1;
        if (delay_q == DelayMax) begin
          state_d = StRun;
        end else begin
          delay_d = delay_q + 1'b1;
        end
      end
      StRun: begin
        enable   = 1'b1;
        cpu_gnt  = 1'b1;
        mem_addr = cpu_addr;
      end
      StErr: ;
      default: state_d = StIdle;
    endcase

    // A restart lets any write of this cycle complete, then starts over at address 0.
    if (load_start) begin
      state_d   = StLoad;
      wr_addr_d = '0;
      count_d   = '0;
      ovf_d     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      wr_addr_q   <= '0;
      count_q     <= '0;
      delay_q     <= '0;
      ovf_q       <= 1'b0;
      addr_hold_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_addr_q   <= wr_addr_d;
      count_q     <= count_d;
      delay_q     <= delay_d;
      ovf_q       <= ovf_d;
      addr_hold_q <= mem_addr;
    end
  end

  assign overflow   = ovf_q;
  assign byte_count = count_q;

endmodule

// File: tb/tb_program_loader.sv
module tb_program_loader;
  localparam int SD    = 4;
  localparam int DEPTH = 1024;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load_start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_last = 1'b0;
  logic [9:0] cpu_addr = 10'd0;
  logic       in_ready, mem_we, cpu_gnt, enable, busy, overflow;
  logic [9:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [10:0] byte_count;

  program_loader #(
    .ADDR_W(10), .DATA_W(8), .TERM(8'hFF), .START_DELAY(SD)
  ) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_addr(cpu_addr), .cpu_gnt(cpu_gnt),
    .enable(enable), .busy(busy), .overflow(overflow), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int vectors = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  logic [7:0] dut_mem [DEPTH];

  // Transaction-level model: how many bytes are stored, whether the terminator is due this
  // cycle, how many delay cycles remain, and whether the processor is running.
  bit         m_load = 0, m_term = 0, m_run = 0, m_ovf = 0;
  int         m_n = 0, m_wait = 0;
  logic [9:0] m_hold = 10'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    bit         e_ready, acc, e_we, e_busy;
    logic [9:0] e_addr;
    logic [7:0] e_wd;
    if (mem_we === 1'b1) dut_mem[mem_addr] = mem_wdata;
    if (chk_en) begin
      e_ready = m_load && (m_n < DEPTH - 1) && !reset;
      acc     = e_ready && in_valid;
      e_we    = acc || (m_term && !reset);
      e_addr  = (m_load || m_term) ? 10'(m_n) : (m_run ? cpu_addr : m_hold);
      e_wd    = acc ? in_data : 8'hFF;
      e_busy  = m_load || m_term || (m_wait > 0);
      check("in_ready", in_ready, e_ready);
      check("mem_we", mem_we, e_we);
      check("mem_addr", mem_addr, e_addr);
      if (e_we) check("mem_wdata", mem_wdata, e_wd);
      check("cpu_gnt", cpu_gnt, m_run);
      check("enable", enable, m_run);
      check("busy", busy, e_busy);
      check("overflow", overflow, m_ovf);
      check("byte_count", byte_count, m_n);
      // Advance to the next cycle.
      if (reset) begin
        m_load = 0; m_term = 0; m_run = 0; m_ovf = 0; m_n = 0; m_wait = 0;
      end else if (load_start) begin
        m_load = 1; m_term = 0; m_run = 0; m_ovf = 0; m_n = 0; m_wait = 0;
      end else if (m_load) begin
        if (acc) begin
          m_n++;
          if (in_last || m_n == DEPTH - 1) begin
            m_load = 0;
            m_term = 1;
            m_ovf  = !in_last;
          end
        end
      end else if (m_term) begin
        m_term = 0;
        if (!m_ovf) m_wait = SD;
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) m_run = 1;
      end
      m_hold = reset ? 10'd0 : e_addr;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input bit last, output int edge_cyc);
    in_valid = 1'b1;
    in_data  = b;
    in_last  = last;
    tick();
    edge_cyc = cyc;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_enable(input string name, input int from);
    int t = 0;
    while (enable !== 1'b1 && t < 30) begin
      tick();
      t++;
    end
    check(name, cyc - from, 1 + SD);
  endtask

  initial begin
    int k, acc_n;
    bit seen;
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    // Reset state.
    check("rst_enable", enable, 0);
    check("rst_busy", busy, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_byte_count", byte_count, 0);

    // Three-byte load.
    pulse_start();
    send(8'h12, 0, k);
    send(8'h34, 0, k);
    send(8'h56, 1, k);
    wait_enable("t1_enable_delay", k);
    check("t1_mem0", dut_mem[0], 8'h12);
    check("t1_mem1", dut_mem[1], 8'h34);
    check("t1_mem2", dut_mem[2], 8'h56);
    check("t1_mem3", dut_mem[3], 8'hFF);
    check("t1_byte_count", byte_count, 3);
    check("t1_overflow", overflow, 0);

    // Processor fetch path.
    cpu_addr = 10'd2;
    #1;
    check("run_mem_addr", mem_addr, 2);
    check("run_cpu_gnt", cpu_gnt, 1);
    check("run_mem_we", mem_we, 0);

    // Same load with gapped valid.
    for (int i = 0; i < 4; i++) dut_mem[i] = 8'h00;
    pulse_start();
    send(8'h12, 0, k);
    tick();
    tick();
    send(8'h34, 0, k);
    tick();
    send(8'h56, 1, k);
    wait_enable("t2_enable_delay", k);
    check("t2_mem0", dut_mem[0], 8'h12);
    check("t2_mem1", dut_mem[1], 8'h34);
    check("t2_mem2", dut_mem[2], 8'h56);
    check("t2_mem3", dut_mem[3], 8'hFF);
    check("t2_byte_count", byte_count, 3);

    // Restart from RUN, then a one-byte load.
    pulse_start();
    check("t3_enable_fall", enable, 0);
    check("t3_gnt_fall", cpu_gnt, 0);
    send(8'h77, 1, k);
    wait_enable("t3_enable_delay", k);
    check("t3_mem0", dut_mem[0], 8'h77);
    check("t3_mem1", dut_mem[1], 8'hFF);

    // Restart mid-load, with a byte accepted on the restart cycle.
    pulse_start();
    send(8'h01, 0, k);
    in_valid = 1'b1; in_data = 8'h02; load_start = 1'b1;
    tick();
    in_valid = 1'b0; load_start = 1'b0;
    send(8'hAA, 1, k);
    wait_enable("t4_enable_delay", k);
    check("t4_mem0", dut_mem[0], 8'hAA);
    check("t4_mem1", dut_mem[1], 8'hFF);
    check("t4_mem2_kept", dut_mem[2], 8'h56);
    check("t4_byte_count", byte_count, 1);

    // Reset during the start delay.
    pulse_start();
    send(8'h33, 1, k);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t5_busy", busy, 0);
    check("t5_mem_addr", mem_addr, 0);
    check("t5_byte_count", byte_count, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (enable !== 1'b0) seen = 1;
    end
    check("t5_enable_never", seen, 0);

    // Overflow: stream 1024 bytes with no end marker.
    pulse_start();
    acc_n = 0;
    for (int i = 0; i < DEPTH; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i) ^ 8'h5A;
      if (in_ready === 1'b1) acc_n++;
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("t6_accepted", acc_n, DEPTH - 1);
    check("t6_mem1022", dut_mem[1022], 8'(1022) ^ 8'h5A);
    check("t6_mem1023", dut_mem[1023], 8'hFF);
    check("t6_overflow", overflow, 1);
    check("t6_busy", busy, 0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (enable !== 1'b0) seen = 1;
    end
    check("t6_enable_never", seen, 0);
    check("t6_overflow_sticky", overflow, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/program_loader.md
# program_loader

Sequences program-memory loading for the microprocessor and then hands the memory port to it. A byte stream is written into the 1024×8 program memory starting at address 0, and an 8'hFF terminator is appended after the last byte. After a fixed start delay the block asserts the processor's `enable` and grants it read access to the memory port. The block sits between the host/boot byte source, the single-port program memory and the processor core.

## Interface
Parameters:
- `ADDR_W`, 10, program memory address width (depth 2^ADDR_W)
- `DATA_W`, 8, memory word and stream byte width
- `TERM`, 8'hFF, terminator word written after the last program byte
- `START_DELAY`, 4, cycles between the terminator write and `enable` rising (range 1..15)

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock
- `reset`  in  1  synchronous active-high reset
- `load_start`  in  1  one-cycle pulse; begins or restarts a load at address 0
- `in_valid`  in  1  stream byte valid
- `in_data`  in  DATA_W  stream byte
- `in_last`  in  1  marks final program byte, qualified by `in_valid`
- `in_ready`  out  1  block accepts a stream byte this cycle
- `mem_we`  out  1  program memory write enable
- `mem_addr`  out  ADDR_W  program memory address
- `mem_wdata`  out  DATA_W  program memory write data
- `cpu_addr`  in  ADDR_W  processor fetch address
- `cpu_gnt`  out  1  processor owns the memory port
- `enable`  out  1  processor run enable
- `busy`  out  1  load or start delay in progress
- `overflow`  out  1  sticky; program exceeded capacity
- `byte_count`  out  ADDR_W+1  data bytes stored by the last load (excludes terminator)

## Operation
- States: IDLE, LOAD, TERM, WAIT, RUN, ERR.
- Reset values: state IDLE, `wr_addr`=0, `byte_count`=0, delay counter 0. All outputs 0: `in_ready`, `mem_we`, `mem_addr`, `mem_wdata`, `cpu_gnt`, `enable`, `busy`, `overflow`.
- IDLE: waits for `load_start`.
- `load_start` in any state: go to LOAD next cycle. Clears `wr_addr`, `byte_count`, `overflow` and `enable`. A load restarted mid-LOAD discards progress; it does not erase memory.
- LOAD:
  - `in_ready`=1 while `wr_addr` < 2^ADDR_W−1.
  - Each accepted byte (`in_valid & in_ready`) drives `mem_we`=1 combinationally, with `mem_addr`=`wr_addr` and `mem_wdata`=`in_data`.
  - On the same edge, `wr_addr` and `byte_count` increment.
  - Accepted with `in_last`: go to TERM.
  - If `wr_addr` reaches 2^ADDR_W−1 without `in_last`: `in_ready` drops, `overflow` is set, and the state goes to TERM.
- TERM: one cycle with `mem_we`=1, `mem_addr`=`wr_addr`, `mem_wdata`=TERM. Next state is WAIT, or ERR if `overflow`.
- WAIT: counts START_DELAY cycles with `mem_we`=0, then goes to RUN.
- RUN:
  - `enable`=1 and `cpu_gnt`=1.
  - `mem_addr`=`cpu_addr`, with `mem_we` held at 0. The processor has read-only access.
  - Remains in RUN until `load_start` or `reset`.
- ERR: terminator has been written, `enable` stays 0, `overflow` stays 1. Only `load_start` or `reset` exits.
- `busy` = state ∈ {LOAD, TERM, WAIT}. `cpu_gnt` is 0 outside RUN.
- Outside LOAD/TERM/RUN: `mem_addr` holds the last value and `mem_we`=0.

## Timing
- `load_start` at edge N: LOAD from cycle N+1. The first byte can be accepted in cycle N+1.
- Throughput: one byte per cycle. `in_data` is written on the edge where it is accepted.
- `in_last` accepted at edge K: terminator written at edge K+1. `enable` rises at edge K+1+START_DELAY.
- `load_start` in RUN at edge N: `enable` and `cpu_gnt` fall in cycle N+1.
- Simultaneous `load_start` and an accepted byte in LOAD: the byte is written, then the restart takes effect (`wr_addr`=0 next cycle).
- `reset` overrides everything, including a mid-load or mid-write cycle.
- `in_valid` low in LOAD: the block stalls indefinitely with no timeout.

## Test plan
- Load 3 bytes 8'h12, 8'h34, 8'h56, last on the third, START_DELAY=4 -> memory[0..3] = 12, 34, 56, FF. `byte_count`=3. `enable` rises 5 cycles after the third byte is accepted. `overflow`=0.
- Same load with `in_valid` gapped (1 0 0 1 0 1) -> identical memory contents and `byte_count`. `enable` timing is relative to the last-byte acceptance.
- Stream 1024 bytes without `in_last` -> bytes 0..1022 are written. `in_ready` drops after 1023 acceptances. memory[1023]=FF, `overflow`=1, state ERR, `enable` stays 0.
- In RUN, drive `cpu_addr`=10'd2 -> `mem_addr`=2, `cpu_gnt`=1, `mem_we`=0. Pulse `load_start` -> `enable`=0 the next cycle; a new 1-byte load writes memory[0..1] = byte, FF.
- `load_start` after 2 bytes of a load, then a 1-byte load of 8'hAA -> memory[0]=AA, memory[1]=FF, `byte_count`=1.
- Assert `reset` during WAIT -> next cycle state IDLE with all outputs 0. `enable` never rises.
